inst_fetcher: RTL and testbench

//  Instruction fetch stage directly upstream of the core decode/execute logic. Uses eei types and constants.

---
 rtl/inst_fetcher.sv | 250 +++++++++++++++++++++++++
 tb/tb_inst_fetcher.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetcher.sv
// ---------------------------------------------------------------------------
// inst_fetcher
//
// Instruction fetch stage sitting directly in front of decode/execute.
// Fetches 32-bit instructions in program order over a 64-bit memory bus
// (ROM at 0x1000, RAM at 0x8000_0000). It picks the correct 32-bit half of
// each bus word and queues {pc, inst} pairs in a small FIFO that the core
// drains. A flush/redirect from the core throws away every piece of stale
// work: queued entries, a response in flight and a request still on the bus.
//
// Optional feature macro: IFETCH_STAT_EN
//   When defined, adds the stall_cycles output. This is a saturating 32-bit
//   count of cycles in which the core was ready but no instruction was
//   available. Only reset clears it.
//
// Parameters
//   FIFO_DEPTH   entries in the {pc, inst} FIFO (power of 2, >= 2)
//   RESET_PC     first fetch address after reset
//
// Ports
//   clk           clock, all state on the rising edge
//   rst           asynchronous, active-low reset
//   mem_valid     fetch request valid (registered)
//   mem_ready     bus accepts the request when mem_valid && mem_ready
//   mem_addr      8-byte aligned request address (registered)
//   mem_rvalid    read data valid, one response per accepted request
//   mem_rdata     64-bit read data
//   if_valid      FIFO head valid
//   if_ready      core pops the head when if_valid && if_ready
//   if_addr       PC of the head instruction
//   if_inst       head instruction bits
//   flush         one-cycle redirect pulse
//   flush_pc      redirect target, bits [1:0] ignored
//   stall_cycles  starved-cycle counter (IFETCH_STAT_EN only)
// ---------------------------------------------------------------------------

package eei;
    localparam int XLEN              = 64;
    localparam int ILEN              = 32;
    localparam int MEMBUS_DATA_WIDTH = 64;

    typedef logic [XLEN-1:0] Addr;
    typedef logic [ILEN-1:0] Inst;

    localparam Addr INITIAL_PC = 64'h0000_0000_0000_1000;
endpackage

module inst_fetcher #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter eei::Addr    RESET_PC   = eei::INITIAL_PC
) (
    input  logic                              clk,
    input  logic                              rst,
    output logic                              mem_valid,
    input  logic                              mem_ready,
    output logic [eei::XLEN-1:0]              mem_addr,
    input  logic                              mem_rvalid,
    input  logic [eei::MEMBUS_DATA_WIDTH-1:0] mem_rdata,
    output logic                              if_valid,
    input  logic                              if_ready,
    output logic [eei::XLEN-1:0]              if_addr,
    output logic [eei::ILEN-1:0]              if_inst,
    input  logic                              flush,
    input  logic [eei::XLEN-1:0]              flush_pc
`ifdef IFETCH_STAT_EN
    ,
    output logic [31:0]                       stall_cycles
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam eei::Addr         PC_STEP = eei::Addr'(4);

    typedef enum logic {
        S_REQ,
        S_WAIT
    } state_t;

    // Fetch control
    state_t           state;
    state_t           state_n;
    logic             drop;
    logic             drop_n;
    eei::Addr         fetch_pc;
    eei::Addr         fetch_pc_n;
    eei::Addr         req_pc;
    logic             mem_valid_n;
    eei::Addr         mem_addr_n;

    // FIFO
    eei::Addr         pc_q   [FIFO_DEPTH];
    eei::Inst         inst_q [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_n;

    // Handshake events for this cycle
    logic             accept;
    logic             rsp;
    logic             push;
    logic             pop;
    eei::Addr         flush_target;
    eei::Inst         rsp_inst;

    function automatic eei::Addr line_addr(input eei::Addr pc);
        return pc & ~eei::Addr'(7);
    endfunction

    function automatic eei::Inst half_select(input logic [eei::MEMBUS_DATA_WIDTH-1:0] rdata,
                                             input logic                              upper);
        return upper ? rdata[63:32] : rdata[31:0];
    endfunction

`ifdef IFETCH_STAT_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction
`endif

    assign accept       = mem_valid && mem_ready;
    assign rsp          = (state == S_WAIT) && mem_rvalid;
    // A response racing a flush belongs to the old path and is discarded.
    assign push         = rsp && !drop && !flush;
    // A pop in the flush cycle is ignored: the whole FIFO is being cleared.
    assign pop          = if_valid && if_ready && !flush;
    assign flush_target = flush_pc & ~eei::Addr'(3);
    assign rsp_inst     = half_select(mem_rdata, req_pc[2]);

    assign if_valid     = (count != '0);
    assign if_addr      = pc_q[rd_ptr];
    assign if_inst      = inst_q[rd_ptr];

    // Next-state computation for the fetch FSM and FIFO occupancy.
    always_comb begin
        state_n    = state;
        drop_n     = drop;
        fetch_pc_n = fetch_pc;
        count_n    = count;

        unique case (state)
            S_REQ: begin
                if (accept) begin
                    state_n = S_WAIT;
                    // With drop already set, the request being accepted is
                    // a stale one held on the bus across a flush; fetch_pc
                    // already points at the redirect target, so leave it.
                    if (!drop) begin
                        fetch_pc_n = fetch_pc + PC_STEP;
                    end
                    if (flush) begin
                        drop_n = 1'b1;
                    end
                end else if (flush && mem_valid) begin
                    // The request stays on the bus until accepted, but its
                    // response must not reach the FIFO.
                    drop_n = 1'b1;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    state_n = S_REQ;
                    drop_n  = 1'b0;
                end else if (flush) begin
                    drop_n = 1'b1;
                end
            end
            default: begin
                state_n = S_REQ;
            end
        endcase

        if (flush) begin
            fetch_pc_n = flush_target;
        end

        if (flush) begin
            count_n = '0;
        end else if (push && !pop) begin
            count_n = count + CNT_ONE;
        end else if (pop && !push) begin
            count_n = count - CNT_ONE;
        end
    end

    // A request is only raised with a free FIFO slot. No push happens while
    // in REQ, so once raised mem_valid holds until it is accepted.
    assign mem_valid_n = (state_n == S_REQ) && (count_n < DEPTH_C);
    assign mem_addr_n  = (mem_valid && !mem_ready) ? mem_addr : line_addr(fetch_pc_n);

    // ---- control stage: FSM, bus request outputs, FIFO pointers ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_REQ;
            drop      <= 1'b0;
            fetch_pc  <= RESET_PC;
            mem_valid <= 1'b0;
            mem_addr  <= line_addr(RESET_PC);
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else begin
            state     <= state_n;
            drop      <= drop_n;
            fetch_pc  <= fetch_pc_n;
            mem_valid <= mem_valid_n;
            mem_addr  <= mem_addr_n;
            count     <= count_n;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
            end
        end
    end

    // ---- data stage: request PC and FIFO storage ----
    always_ff @(posedge clk) begin
        if (accept) begin
            req_pc <= fetch_pc;
        end
        if (push) begin
            pc_q[wr_ptr]   <= req_pc;
            inst_q[wr_ptr] <= rsp_inst;
        end
    end

`ifdef IFETCH_STAT_EN
    // ---- statistics ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= 32'd0;
        end else if (if_ready && !if_valid) begin
            stall_cycles <= sat_inc32(stall_cycles);
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetcher.sv
// ---------------------------------------------------------------------------
// tb_inst_fetcher
//
// Bench for inst_fetcher. Inputs are driven and outputs sampled on the
// falling clock edge. A behavioural bus responder returns one 64-bit word
// per accepted request after a configurable delay. The reference model
// tracks the program-order instruction stream: the core must see
// consecutive PCs from the last reset or redirect, each with the
// instruction stored at that address.
// ---------------------------------------------------------------------------
module tb_inst_fetcher;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic        mem_ready;
    logic [63:0] mem_addr;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [63:0] if_addr;
    logic [31:0] if_inst;
    logic        flush;
    logic [63:0] flush_pc;
`ifdef IFETCH_STAT_EN
    logic [31:0] stall_cycles;
    logic [31:0] stall_model;
`endif

    int          checks = 0;
    int          errors = 0;

    // Stimulus knobs
    int unsigned ready_pct = 100;
    int unsigned core_pct  = 100;
    int unsigned dly_min   = 1;
    int unsigned dly_max   = 1;
    bit          do_flush  = 1'b0;
    logic [63:0] do_flush_pc = 64'd0;

    // Bus responder and reference model state
    bit          pend = 1'b0;
    logic [63:0] pend_addr = 64'd0;
    int          pend_cnt = 0;
    logic [63:0] exp_pc = 64'h1000;
    int          n_pop = 0;
    int          tot_pop = 0;
    int          cyc = 0;
    logic [63:0] acc_q[$];
    bit          prev_stall = 1'b0;
    logic [63:0] prev_addr = 64'd0;

    inst_fetcher #(
        .FIFO_DEPTH (4),
        .RESET_PC   (64'h1000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_addr     (mem_addr),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .if_valid     (if_valid),
        .if_ready     (if_ready),
        .if_addr      (if_addr),
        .if_inst      (if_inst),
        .flush        (flush),
        .flush_pc     (flush_pc)
`ifdef IFETCH_STAT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory contents: 32-bit instruction stored at a 4-byte aligned address.
    function automatic logic [31:0] inst_at(input logic [63:0] a);
        if (a == 64'h1000) return 32'h0010_0093;
        if (a == 64'h1004) return 32'h0000_0013;
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [63:0] word_at(input logic [63:0] a);
        logic [63:0] base;
        base = a & ~64'h7;
        return {inst_at(base + 64'h4), inst_at(base)};
    endfunction

    // One clock cycle: check, drive inputs, update model, advance.
    task automatic tick();
        bit pend_before;
        bit rv;
        bit rdy;
        bit cr;
        bit acc;
        bit popd;

        if (prev_stall) begin
            chk("mem_valid_hold", 64'(mem_valid), 64'd1);
            chk("mem_addr_hold", mem_addr, prev_addr);
        end
        if (mem_valid) chk("mem_addr_align", 64'(mem_addr[2:0]), 64'd0);
`ifdef IFETCH_STAT_EN
        chk("stall_cycles", 64'(stall_cycles), 64'(stall_model));
`endif

        pend_before = pend;
        rv = pend && (pend_cnt == 0);
        mem_rvalid = rv;
        mem_rdata  = rv ? word_at(pend_addr) : {$urandom, $urandom};
        if (rv) pend = 1'b0;
        else if (pend) pend_cnt--;

        rdy = ($urandom_range(99) < ready_pct);
        cr  = ($urandom_range(99) < core_pct);
        mem_ready = rdy;
        if_ready  = cr;
        flush     = do_flush;
        flush_pc  = do_flush_pc;

        acc = mem_valid && rdy;
        if (acc) begin
            chk("one_outstanding", 64'(pend_before), 64'd0);
            pend      = 1'b1;
            pend_addr = mem_addr;
            pend_cnt  = int'($urandom_range(dly_max, dly_min)) - 1;
            acc_q.push_back(mem_addr);
        end

        popd = if_valid && cr && !do_flush;
        if (popd) begin
            chk("if_addr", if_addr, exp_pc);
            chk("if_inst", 64'(if_inst), 64'(inst_at(exp_pc)));
            exp_pc = exp_pc + 64'd4;
            n_pop++;
            tot_pop++;
        end
        if (do_flush) exp_pc = do_flush_pc & ~64'h3;

`ifdef IFETCH_STAT_EN
        if (cr && !if_valid && stall_model != 32'hFFFF_FFFF) stall_model = stall_model + 32'd1;
`endif

        prev_stall = mem_valid && !rdy;
        prev_addr  = mem_addr;
        do_flush   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // Reset for two cycles; optionally leave a stale response that the bus
    // delivers in the first cycle after release.
    task automatic do_reset(input bit stale);
        rst        = 1'b0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        if_ready   = 1'b0;
        flush      = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mem_valid", 64'(mem_valid), 64'd0);
        chk("rst_if_valid", 64'(if_valid), 64'd0);
`ifdef IFETCH_STAT_EN
        chk("rst_stall_cycles", 64'(stall_cycles), 64'd0);
        stall_model = 32'd0;
`endif
        pend       = stale;
        pend_addr  = 64'h2000;
        pend_cnt   = 0;
        prev_stall = 1'b0;
        exp_pc     = 64'h1000;
        n_pop      = 0;
        cyc        = 0;
        do_flush   = 1'b0;
        acc_q.delete();
        rst = 1'b1;
    endtask

    task automatic wait_acc(input int n0);
        int k;
        k = 0;
        while (acc_q.size() <= n0 && k < 200) begin
            tick();
            k++;
        end
        chk("accept_timeout", 64'(acc_q.size() > n0), 64'd1);
    endtask

    initial begin
        int first_v;
        int n0;
        int p0;
        int k;
        logic [63:0] held;

        rst        = 1'b0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 64'd0;
        if_ready   = 1'b0;
        flush      = 1'b0;
        flush_pc   = 64'd0;
`ifdef IFETCH_STAT_EN
        stall_model = 32'd0;
`endif

        // Reset release with a stale response, in-order fetch from ROM
        ready_pct = 100; core_pct = 100; dly_min = 1; dly_max = 1;
        do_reset(1'b1);
        first_v = -1;
        repeat (10) begin
            if (first_v < 0 && if_valid) first_v = cyc;
            tick();
        end
        chk("t1_latency", 64'(first_v), 64'd3);
        chk("t1_req0", acc_q[0], 64'h1000);
        chk("t1_req1", acc_q[1], 64'h1000);
        chk("t1_pops", 64'(n_pop >= 2), 64'd1);

        // Core not ready: exactly four entries buffered, then drained in order
        do_reset(1'b0);
        core_pct = 0;
        repeat (20) tick();
        chk("t2_accepts", 64'(acc_q.size()), 64'd4);
        chk("t2_no_fifth_req", 64'(mem_valid), 64'd0);
        chk("t2_if_valid", 64'(if_valid), 64'd1);
        core_pct = 100;
        repeat (4) tick();
        chk("t2_pops", 64'(n_pop), 64'd4);

        // Flush while waiting on a response
        dly_min = 3; dly_max = 3;
        k = 0;
        while (!(pend && pend_cnt > 0) && k < 100) begin
            tick();
            k++;
        end
        chk("t3_in_wait", 64'(pend && pend_cnt > 0), 64'd1);
        n0 = acc_q.size();
        p0 = n_pop;
        do_flush = 1'b1; do_flush_pc = 64'h8000_0008;
        tick();
        wait_acc(n0);
        chk("t3_next_addr", acc_q[n0], 64'h8000_0008);
        repeat (20) tick();
        chk("t3_popped", 64'(n_pop > p0), 64'd1);

        // Flush coincident with a response and a pop, two entries queued
        dly_min = 1; dly_max = 1;
        do_reset(1'b0);
        core_pct = 0;
        repeat (6) tick();
        chk("t4_rsp_now", 64'(pend && pend_cnt == 0), 64'd1);
        chk("t4_fifo_nonempty", 64'(if_valid), 64'd1);
        core_pct = 100;
        n0 = acc_q.size();
        do_flush = 1'b1; do_flush_pc = 64'h8000_0042;
        tick();
        chk("t4_empty", 64'(if_valid), 64'd0);
        wait_acc(n0);
        chk("t4_next_addr", acc_q[n0], 64'h8000_0040);
        repeat (10) tick();

        // Bus stall with a flush in the middle of it
        do_reset(1'b0);
        ready_pct = 0;
        repeat (3) tick();
        chk("t5_valid", 64'(mem_valid), 64'd1);
        held = mem_addr;
        repeat (2) tick();
        do_flush = 1'b1; do_flush_pc = 64'h8000_0100;
        tick();
        repeat (2) tick();
        chk("t5_held", mem_addr, held);
        ready_pct = 100;
        n0 = acc_q.size();
        wait_acc(n0);
        chk("t5_stale_accept", acc_q[n0], held);
        wait_acc(n0 + 1);
        chk("t5_refetch", acc_q[n0 + 1], 64'h8000_0100);
        repeat (10) tick();
        chk("t5_popped", 64'(n_pop > 0), 64'd1);

`ifdef IFETCH_STAT_EN
        // Starved core with slow memory
        do_reset(1'b0);
        ready_pct = 100; core_pct = 100; dly_min = 3; dly_max = 3;
        repeat (40) tick();
        chk("t6_stall_count", 64'(stall_cycles), 64'(stall_model));
        chk("t6_stall_nonzero", 64'(stall_cycles != 32'd0), 64'd1);
`endif

        // Randomised traffic with redirects and occasional resets
        do_reset(1'b0);
        ready_pct = 70; core_pct = 60; dly_min = 1; dly_max = 4;
        p0 = tot_pop;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 2) begin
                do_flush = 1'b1;
                if ($urandom_range(1) == 1)
                    do_flush_pc = 64'h8000_0000 + 64'($urandom_range(4095));
                else
                    do_flush_pc = 64'h1000 + 64'($urandom_range(1023));
            end
            if ($urandom_range(999) == 0) do_reset(pend);
            tick();
        end
        chk("rand_progress", 64'((tot_pop - p0) > 100), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
